// File: rtl/aer_receiver.sv
// aer_receiver
//   Input-side AER slave. Terminates the 4-phase AERIN_REQ/AERIN_ACK link
//   from the image encoder, queues captured pixel IDs in a small FIFO and
//   presents them to the core over a valid/ready interface. It also keeps
//   a saturating per-inference event count that FLUSH clears.
//
// Ports
//   CLK          clock, all logic on the rising edge
//   RST          synchronous reset, active-low
//   AERIN_ADDR   AER address (bundled data, stable while AERIN_REQ is high)
//   AERIN_REQ    AER request, asynchronous to CLK
//   AERIN_ACK    AER acknowledge, registered
//   SPIKE_ADDR   head-of-FIFO address (0 when the FIFO is empty)
//   SPIKE_VALID  FIFO non-empty
//   SPIKE_READY  core accepts the head event when high with SPIKE_VALID
//   FLUSH        single-cycle pulse, empties the FIFO and clears EVENT_COUNT
//   FIFO_FULL    FIFO occupancy equals FIFO_DEPTH
//   EVENT_COUNT  events accepted since reset/FLUSH, saturating
module aer_receiver #(
   parameter int ADDR_BITS  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int COUNT_BITS = 9
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [ADDR_BITS-1:0]  AERIN_ADDR,
   input  logic                  AERIN_REQ,
   output logic                  AERIN_ACK,
   output logic [ADDR_BITS-1:0]  SPIKE_ADDR,
   output logic                  SPIKE_VALID,
   input  logic                  SPIKE_READY,
   input  logic                  FLUSH,
   output logic                  FIFO_FULL,
   output logic [COUNT_BITS-1:0] EVENT_COUNT
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]      PTR_ONE   = (PTR_W+1)'(1);
   localparam logic [COUNT_BITS-1:0] COUNT_ONE = COUNT_BITS'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACKED   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   // Saturating increment: the counter sticks at its all-ones value.
   function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] v);
      return (v == {COUNT_BITS{1'b1}}) ? v : v + COUNT_ONE;
   endfunction

   logic                  req_sync_p0;
   logic                  req_sync_p1;
   state_t                state;
   logic                  ack_q;
   logic [COUNT_BITS-1:0] count_q;
   logic [PTR_W:0]        wr_ptr;
   logic [PTR_W:0]        rd_ptr;
   logic [ADDR_BITS-1:0]  fifo_mem [FIFO_DEPTH];

   logic fifo_empty;
   logic fifo_full;
   logic push;
   logic pop;

   // Extra MSB on the pointers separates "full" from "empty" when the
   // index bits match.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

   // Eligibility uses the pre-edge occupancy, so a full FIFO that is being
   // popped this cycle still refuses the push; the FSM retries next cycle.
   assign push = (state == IDLE) && req_sync_p1 && !fifo_full;
   assign pop  = !fifo_empty && SPIKE_READY;

   // Stage p0/p1: two-flop synchroniser for the asynchronous request.
   // Handshake FSM, FIFO pointers and event counter follow on req_sync_p1.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         req_sync_p0 <= 1'b0;
         req_sync_p1 <= 1'b0;
         state       <= IDLE;
         ack_q       <= 1'b0;
         count_q     <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         req_sync_p0 <= AERIN_REQ;
         req_sync_p1 <= req_sync_p0;

         // FLUSH does not touch the handshake: an acked event still
         // completes its return-to-zero phase, only its data is dropped.
         case (state)
            IDLE: begin
               if (push) begin
                  ack_q <= 1'b1;
                  state <= ACKED;
               end
            end
            ACKED: begin
               if (!req_sync_p1) begin
                  ack_q <= 1'b0;
                  state <= RELEASE;
               end
            end
            RELEASE: begin
               // One guaranteed ACK-low cycle before a new capture.
               state <= IDLE;
            end
            default: begin
               ack_q <= 1'b0;
               state <= IDLE;
            end
         endcase

         if (FLUSH) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
         end else begin
            if (push) begin
               wr_ptr  <= wr_ptr + PTR_ONE;
               count_q <= sat_inc(count_q);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_ONE;
            end
         end
      end
   end

   // Storage carries data only; validity comes from the pointers, so it
   // needs no reset. The address is sampled on the push edge alone.
   always_ff @(posedge CLK) begin
      if (push && !FLUSH) begin
         fifo_mem[wr_ptr[PTR_W-1:0]] <= AERIN_ADDR;
      end
   end

   assign AERIN_ACK   = ack_q;
   assign SPIKE_VALID = !fifo_empty;
   assign SPIKE_ADDR  = fifo_empty ? '0 : fifo_mem[rd_ptr[PTR_W-1:0]];
   assign FIFO_FULL   = fifo_full;
   assign EVENT_COUNT = count_q;

endmodule

// File: tb/tb_aer_receiver.sv
// tb_aer_receiver
//   Directed bench for aer_receiver. The sender pushes each expected
//   address into a scoreboard queue when it raises AERIN_REQ; an
//   independent monitor pops and compares whenever the core side accepts
//   an event (SPIKE_VALID && SPIKE_READY). Inputs change 1 ns after a
//   rising edge, outputs are sampled 1 ns after the edge or on the
//   falling edge.
module tb_aer_receiver;

   localparam int AW    = 8;
   localparam int DEPTH = 4;
   localparam int CW    = 9;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] aerin_addr = '0;
   logic          aerin_req = 1'b0;
   logic          aerin_ack;
   logic [AW-1:0] spike_addr;
   logic          spike_valid;
   logic          spike_ready = 1'b0;
   logic          flush = 1'b0;
   logic          fifo_full;
   logic [CW-1:0] event_count;

   int            checks = 0;
   int            errors = 0;
   logic [AW-1:0] sb[$];
   bit            no_full_mode = 1'b0;

   aer_receiver #(
      .ADDR_BITS (AW),
      .FIFO_DEPTH(DEPTH),
      .COUNT_BITS(CW)
   ) dut (
      .CLK        (clk),
      .RST        (rst_n),
      .AERIN_ADDR (aerin_addr),
      .AERIN_REQ  (aerin_req),
      .AERIN_ACK  (aerin_ack),
      .SPIKE_ADDR (spike_addr),
      .SPIKE_VALID(spike_valid),
      .SPIKE_READY(spike_ready),
      .FLUSH      (flush),
      .FIFO_FULL  (fifo_full),
      .EVENT_COUNT(event_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: one comparison per accepted event.
   always @(negedge clk) begin
      logic [AW-1:0] exp_addr;
      if (rst_n && !flush && spike_valid && spike_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got 0x%0h, expected no event at %0t", spike_addr, $time);
         end else begin
            exp_addr = sb.pop_front();
            check("spike_addr_order", 32'(spike_addr), 32'(exp_addr));
         end
      end
      if (no_full_mode) check("stream_never_full", 32'(fifo_full), 32'd0);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Returns the number of edges until AERIN_ACK reaches val (or limit).
   task automatic wait_ack(input logic val, input int limit, output int n);
      n = 0;
      while (aerin_ack !== val && n < limit) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic raise_req(input logic [AW-1:0] a, input bit measure);
      int n;
      aerin_addr = a;
      aerin_req  = 1'b1;
      sb.push_back(a);
      wait_ack(1'b1, 50, n);
      if (measure) check("req_rise_to_ack_rise_edges", 32'(n), 32'd3);
      else         check("ack_rise", 32'(aerin_ack), 32'd1);
   endtask

   task automatic drop_req(input bit measure);
      int n;
      aerin_req = 1'b0;
      wait_ack(1'b0, 50, n);
      if (measure) check("req_fall_to_ack_fall_edges", 32'(n), 32'd3);
      else         check("ack_fall", 32'(aerin_ack), 32'd0);
      tick(1);
   endtask

   task automatic send(input logic [AW-1:0] a);
      raise_req(a, 1'b0);
      drop_req(1'b0);
   endtask

   task automatic do_flush();
      flush = 1'b1;
      sb.delete();
      tick(1);
      flush = 1'b0;
   endtask

   task automatic drain();
      int n;
      spike_ready = 1'b1;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         tick(1);
         n++;
      end
      tick(2);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      check("valid_after_drain", 32'(spike_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      tick(3);
      check("rst_ack", 32'(aerin_ack), 32'd0);
      check("rst_valid", 32'(spike_valid), 32'd0);
      check("rst_addr", 32'(spike_addr), 32'd0);
      check("rst_full", 32'(fifo_full), 32'd0);
      check("rst_count", 32'(event_count), 32'd0);
      rst_n = 1'b1;
      tick(2);

      // 1: single event with measured handshake latency
      spike_ready = 1'b1;
      raise_req(8'h45, 1'b1);
      check("t1_valid", 32'(spike_valid), 32'd1);
      check("t1_addr", 32'(spike_addr), 32'h45);
      check("t1_count", 32'(event_count), 32'd1);
      tick(1);
      check("t1_valid_one_cycle", 32'(spike_valid), 32'd0);
      drop_req(1'b1);
      check("t1_count_after", 32'(event_count), 32'd1);

      // 2 + 4: back-pressure, stall when full, pop blocks same-cycle push
      do_flush();
      spike_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) send(8'(8'h10 + i));
      check("t2_full", 32'(fifo_full), 32'd1);
      check("t2_head_held", 32'(spike_addr), 32'h10);
      check("t2_count4", 32'(event_count), 32'd4);
      aerin_addr = 8'h14;
      aerin_req  = 1'b1;
      sb.push_back(8'h14);
      tick(8);
      check("t2_stalled_ack", 32'(aerin_ack), 32'd0);
      check("t2_still_full", 32'(fifo_full), 32'd1);
      check("t2_head_stable", 32'(spike_addr), 32'h10);
      spike_ready = 1'b1;
      tick(1);
      spike_ready = 1'b0;
      check("t4_pop_blocks_push_ack", 32'(aerin_ack), 32'd0);
      check("t4_pop_blocks_push_full", 32'(fifo_full), 32'd0);
      check("t4_count_unchanged", 32'(event_count), 32'd4);
      tick(1);
      check("t4_push_next_edge_ack", 32'(aerin_ack), 32'd1);
      check("t4_push_next_edge_full", 32'(fifo_full), 32'd1);
      check("t2_count5", 32'(event_count), 32'd5);
      drop_req(1'b0);
      drain();
      check("t2_count_final", 32'(event_count), 32'd5);

      // 3: streaming 16 events with a 100 ns sender gap
      do_flush();
      spike_ready  = 1'b1;
      no_full_mode = 1'b1;
      for (int i = 0; i < 16; i++) begin
         send(8'(i));
         #100;
      end
      tick(5);
      no_full_mode = 1'b0;
      check("t3_count16", 32'(event_count), 32'd16);
      drain();

      // 5: FLUSH with 3 queued while ACKED
      do_flush();
      spike_ready = 1'b0;
      send(8'h20);
      send(8'h21);
      raise_req(8'h22, 1'b0);
      flush = 1'b1;
      sb.delete();
      tick(1);
      flush = 1'b0;
      check("t5_flush_valid", 32'(spike_valid), 32'd0);
      check("t5_flush_count", 32'(event_count), 32'd0);
      check("t5_flush_ack_kept", 32'(aerin_ack), 32'd1);
      drop_req(1'b1);
      spike_ready = 1'b1;
      send(8'h77);
      tick(2);
      check("t5_count_after", 32'(event_count), 32'd1);
      drain();

      // 6: reset mid-handshake with REQ held high
      do_flush();
      spike_ready = 1'b0;
      raise_req(8'h5A, 1'b0);
      rst_n = 1'b0;
      sb.delete();
      tick(2);
      check("t6_rst_ack", 32'(aerin_ack), 32'd0);
      check("t6_rst_valid", 32'(spike_valid), 32'd0);
      check("t6_rst_count", 32'(event_count), 32'd0);
      check("t6_rst_addr", 32'(spike_addr), 32'd0);
      rst_n = 1'b1;
      sb.push_back(8'h5A);
      begin
         int n;
         wait_ack(1'b1, 50, n);
         check("t6_reack_edges", 32'(n), 32'd3);
      end
      check("t6_recapture_valid", 32'(spike_valid), 32'd1);
      check("t6_recapture_addr", 32'(spike_addr), 32'h5A);
      check("t6_recapture_count", 32'(event_count), 32'd1);
      drop_req(1'b0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
